// File: rtl/compute_tile_sequencer.sv
// compute_tile_sequencer: walks the core through weight load, activation stream, drain and
// output ping-pong flip for each tile of a run. Define TILE_SEQ_PERF_EN for the perf counters.
module compute_tile_sequencer #(
  parameter int ADDR_W     = 15,
  parameter int W_BEATS    = 32,
  parameter int ACT_RD_LAT = 1,
  parameter int DRAIN_CYC  = 67
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic [7:0]        cfg_num_tiles,
  input  logic [11:0]       cfg_act_len,
  input  logic [ADDR_W-1:0] cfg_w_base,
  input  logic [ADDR_W-1:0] cfg_a_base,
  output logic              w_rd_en,
  output logic [ADDR_W-1:0] w_rd_addr,
  input  logic              w_rd_valid,
  output logic              act_rd_en,
  output logic [ADDR_W-1:0] act_rd_addr,
  output logic              act_pe_valid,
  output logic              start_calc,
  output logic              pingpang,
  output logic              busy,
  output logic              done,
  output logic [7:0]        tile_idx
`ifdef TILE_SEQ_PERF_EN
  ,
  output logic [31:0]       perf_busy_cyc,
  output logic [31:0]       perf_wwait_cyc
`endif
);

  localparam int WCW = $clog2(W_BEATS + 1);
  localparam int CW  = 16;

  typedef enum logic [2:0] {IDLE, LOAD_W, WAIT_W, SETTLE, STREAM, DRAIN, NEXT} state_t;

  state_t            state;
  logic [7:0]        num_tiles_q;
  logic [11:0]       act_len_q;
  logic [12:0]       stream_last_q;
  logic [ADDR_W-1:0] w_ptr;
  logic [ADDR_W-1:0] act_ptr;
  logic [CW-1:0]     cnt;
  logic [11:0]       act_left;
  logic [WCW-1:0]    wcnt;
  logic [ACT_RD_LAT:0] vld_pipe;
  logic              w_last;

  // vld_pipe[0] is the read request itself; the tail is what the core sees
  assign act_rd_en    = vld_pipe[0];
  assign act_pe_valid = vld_pipe[ACT_RD_LAT];

  // Last weight beat is either already counted or arriving this cycle
  assign w_last = (wcnt == WCW'(W_BEATS)) || (w_rd_valid && (wcnt == WCW'(W_BEATS - 1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      num_tiles_q   <= '0;
      act_len_q     <= '0;
      stream_last_q <= '0;
      w_ptr         <= '0;
      act_ptr       <= '0;
      cnt           <= '0;
      act_left      <= '0;
      wcnt          <= '0;
      vld_pipe      <= '0;
      w_rd_en       <= 1'b0;
      w_rd_addr     <= '0;
      act_rd_addr   <= '0;
      start_calc    <= 1'b0;
      pingpang      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      tile_idx      <= '0;
    end else begin
      start_calc  <= 1'b0;
      done        <= 1'b0;
      vld_pipe[0] <= 1'b0;
      for (int i = 1; i <= ACT_RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
      // Valid beats can land while requests are still going out
      if ((state == LOAD_W || state == WAIT_W) && w_rd_valid && (wcnt != WCW'(W_BEATS)))
        wcnt <= wcnt + WCW'(1);

      if (cfg_abort && state != IDLE) begin
        state    <= IDLE;
        busy     <= 1'b0;
        w_rd_en  <= 1'b0;
        vld_pipe <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (cfg_start) begin
              num_tiles_q   <= cfg_num_tiles;
              act_len_q     <= cfg_act_len;
              stream_last_q <= (cfg_act_len == 12'd0) ? 13'(ACT_RD_LAT)
                                                      : 13'(cfg_act_len) + 13'(ACT_RD_LAT) - 13'd1;
              w_ptr         <= cfg_w_base;
              act_ptr       <= cfg_a_base;
              tile_idx      <= '0;
              cnt           <= '0;
              wcnt          <= '0;
              if (cfg_num_tiles == 8'd0) begin
                done <= 1'b1;
              end else begin
                state <= LOAD_W;
                busy  <= 1'b1;
              end
            end
          end
          LOAD_W: begin
            w_rd_en   <= 1'b1;
            w_rd_addr <= w_ptr;
            w_ptr     <= w_ptr + ADDR_W'(1);
            cnt       <= cnt + CW'(1);
            if (cnt == CW'(W_BEATS - 1)) begin
              state <= WAIT_W;
              cnt   <= '0;
            end
          end
          WAIT_W: begin
            w_rd_en <= 1'b0;
            if (w_last) state <= SETTLE;
          end
          SETTLE: begin
            cnt <= cnt + CW'(1);
            if (cnt == CW'(1)) begin
              state      <= STREAM;
              cnt        <= '0;
              start_calc <= 1'b1;
              act_left   <= '0;
              if (act_len_q != 12'd0) begin
                vld_pipe[0] <= 1'b1;
                act_rd_addr <= act_ptr;
                act_ptr     <= act_ptr + ADDR_W'(1);
                act_left    <= act_len_q - 12'd1;
              end
            end
          end
          STREAM: begin
            cnt <= cnt + CW'(1);
            if (act_left != 12'd0) begin
              vld_pipe[0] <= 1'b1;
              act_rd_addr <= act_ptr;
              act_ptr     <= act_ptr + ADDR_W'(1);
              act_left    <= act_left - 12'd1;
            end
            // Hold STREAM until the last delayed valid has been presented
            if (cnt == CW'(stream_last_q)) begin
              state <= DRAIN;
              cnt   <= '0;
            end
          end
          DRAIN: begin
            cnt <= cnt + CW'(1);
            if (cnt == CW'(DRAIN_CYC - 1)) begin
              state <= NEXT;
              cnt   <= '0;
            end
          end
          NEXT: begin
            pingpang <= ~pingpang;
            tile_idx <= tile_idx + 8'd1;
            if (tile_idx + 8'd1 == num_tiles_q) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= LOAD_W;
              wcnt  <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef TILE_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_busy_cyc  <= '0;
      perf_wwait_cyc <= '0;
    end else if (state == IDLE && cfg_start) begin
      perf_busy_cyc  <= '0;
      perf_wwait_cyc <= '0;
    end else begin
      if (busy && perf_busy_cyc != '1) perf_busy_cyc <= perf_busy_cyc + 32'd1;
      if (state == WAIT_W && perf_wwait_cyc != '1) perf_wwait_cyc <= perf_wwait_cyc + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_compute_tile_sequencer.sv
// Scoreboard bench for compute_tile_sequencer: expected addresses/tiles queued at start,
// a negedge monitor (which also models the weight banks) pops and compares.
module tb_compute_tile_sequencer;
  localparam int ADDR_W = 15;
  localparam int WB     = 32;
  localparam int LAT    = 1;
  localparam int DRAIN  = 67;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_start = 1'b0, cfg_abort = 1'b0;
  logic [7:0] cfg_num_tiles = '0;
  logic [11:0] cfg_act_len = '0;
  logic [ADDR_W-1:0] cfg_w_base = '0, cfg_a_base = '0;
  logic w_rd_en, act_rd_en, act_pe_valid, start_calc, pingpang, busy, done;
  logic w_rd_valid = 1'b0;
  logic [ADDR_W-1:0] w_rd_addr, act_rd_addr;
  logic [7:0] tile_idx;
`ifdef TILE_SEQ_PERF_EN
  logic [31:0] perf_busy_cyc, perf_wwait_cyc;
`endif

  compute_tile_sequencer #(.ADDR_W(ADDR_W), .W_BEATS(WB), .ACT_RD_LAT(LAT), .DRAIN_CYC(DRAIN)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_num_tiles(cfg_num_tiles), .cfg_act_len(cfg_act_len),
    .cfg_w_base(cfg_w_base), .cfg_a_base(cfg_a_base),
    .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_valid(w_rd_valid),
    .act_rd_en(act_rd_en), .act_rd_addr(act_rd_addr), .act_pe_valid(act_pe_valid),
    .start_calc(start_calc), .pingpang(pingpang), .busy(busy), .done(done), .tile_idx(tile_idx)
`ifdef TILE_SEQ_PERF_EN
    , .perf_busy_cyc(perf_busy_cyc), .perf_wwait_cyc(perf_wwait_cyc)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;

  typedef struct { int idx; logic pp; } tile_t;
  logic [ADDR_W-1:0] exp_w[$], exp_a[$];
  int exp_pe[$], vq[$];
  tile_t exp_tile[$];

  // run context, written by stimulus only
  int gen = 0, mon_L = 0, s_cyc = 0, stall_until = 0;
  bit mon_zero = 0, run_active = 0, rand_gaps = 0;
  logic pp_model = 1'b0;
  // monitor-owned state
  int done_cnt = 0, sc_cnt = 0, last_sc = 0, done_cyc = 0;
  int b_gen = 0, b_pending = 0, b_vtot = 0;
  bit w_seen = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  // Weight-bank model plus output monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      w_rd_valid = 1'b0;
      b_pending  = 0;
      b_vtot     = 0;
    end else begin
      if (b_gen != gen) begin
        b_gen = gen; b_pending = 0; b_vtot = 0; w_seen = 0;
      end
      // valid driven now reflects requests from earlier cycles: one-cycle read latency
      w_rd_valid = (b_pending > 0) && (cyc >= stall_until) && !(rand_gaps && $urandom_range(3) == 0);
      if (w_rd_valid) begin
        b_pending--;
        b_vtot++;
        if (b_vtot % WB == 0) vq.push_back(cyc);
      end
      if (w_rd_en) b_pending++;

      if (w_rd_en) begin
        if (!w_seen) begin
          w_seen = 1;
          chk("first_w_rd_cycle", cyc, s_cyc + 2);
        end
        chk("w_rd_expected", exp_w.size() > 0, 1);
        if (exp_w.size() > 0) chk("w_rd_addr", w_rd_addr, exp_w.pop_front());
      end
      if (act_rd_en) begin
        chk("act_rd_expected", exp_a.size() > 0, 1);
        if (exp_a.size() > 0) chk("act_rd_addr", act_rd_addr, exp_a.pop_front());
        exp_pe.push_back(cyc + LAT);
      end
      if (act_pe_valid) begin
        chk("pe_valid_expected", exp_pe.size() > 0, 1);
        if (exp_pe.size() > 0) chk("pe_valid_cycle", cyc, exp_pe.pop_front());
      end
      if (start_calc) begin
        tile_t t;
        sc_cnt++;
        last_sc = cyc;
        chk("start_calc_expected", exp_tile.size() > 0, 1);
        if (exp_tile.size() > 0) begin
          t = exp_tile.pop_front();
          chk("tile_idx", tile_idx, t.idx);
          chk("pingpang_at_tile", pingpang, t.pp);
        end
        chk("weights_complete", vq.size() > 0, 1);
        if (vq.size() > 0) chk("settle_to_stream", cyc, vq.pop_front() + 3);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_expected", run_active, 1);
        chk("busy_at_done", busy, 0);
        chk("done_cycle", cyc, mon_zero ? s_cyc + 1
                                        : last_sc + ((mon_L == 0) ? 1 : mon_L) + LAT + DRAIN + 1);
      end
    end
  end

  task automatic flush_all();
    exp_w.delete(); exp_a.delete(); exp_pe.delete(); exp_tile.delete(); vq.delete();
    run_active = 0;
    gen++;
  endtask

  task automatic start_run(input int n, input int L, input logic [ADDR_W-1:0] wb, input logic [ADDR_W-1:0] ab);
    tile_t t;
    for (int ti = 0; ti < n; ti++) begin
      for (int b = 0; b < WB; b++) exp_w.push_back(ADDR_W'(int'(wb) + ti * WB + b));
      for (int b = 0; b < L; b++) exp_a.push_back(ADDR_W'(int'(ab) + ti * L + b));
      t.idx = ti;
      t.pp  = pp_model ^ ti[0];
      exp_tile.push_back(t);
    end
    mon_L = L; mon_zero = (n == 0); run_active = 1;
    gen++;
    @(negedge clk);
    cfg_num_tiles = 8'(n); cfg_act_len = 12'(L); cfg_w_base = wb; cfg_a_base = ab;
    cfg_start = 1'b1;
    s_cyc = cyc;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic run_and_check(input string tag, input int n, input int L,
                               input logic [ADDR_W-1:0] wb, input logic [ADDR_W-1:0] ab);
    int d0, sc0;
    bit saw_busy;
    d0 = done_cnt; sc0 = sc_cnt; saw_busy = 0;
    start_run(n, L, wb, ab);
    for (int i = 0; i < 4000; i++) begin
      if (busy) saw_busy = 1;
      if (done_cnt != d0) break;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    run_active = 0;
    chk({tag, "_done_count"}, done_cnt - d0, 1);
    chk({tag, "_start_calc_count"}, sc_cnt - sc0, n);
    chk({tag, "_busy_seen"}, saw_busy, n != 0);
    chk({tag, "_w_left"}, exp_w.size(), 0);
    chk({tag, "_a_left"}, exp_a.size(), 0);
    chk({tag, "_pe_left"}, exp_pe.size(), 0);
    chk({tag, "_tiles_left"}, exp_tile.size(), 0);
    pp_model = pp_model ^ n[0];
    chk({tag, "_pingpang_end"}, pingpang, pp_model);
    chk({tag, "_tile_idx_end"}, tile_idx, n);
    chk({tag, "_busy_end"}, busy, 0);
  endtask

  initial begin
    #1;
    chk("reset_outputs", {w_rd_en, w_rd_addr, act_rd_en, act_rd_addr, act_pe_valid,
                          start_calc, pingpang, busy, done, tile_idx}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single tile, ideal banks
    run_and_check("single", 1, 16, 15'h100, 15'h200);
    chk("single_total_cycles", done_cyc - s_cyc, 1 + 32 + 2 + 2 + 16 + LAT + DRAIN + 1);
`ifdef TILE_SEQ_PERF_EN
    chk("perf_busy", perf_busy_cyc, 121);
    chk("perf_wwait", perf_wwait_cyc, 2);
`endif

    run_and_check("three", 3, 8, 15'h040, 15'h300);

    // weight valids withheld 20 cycles past the end of LOAD_W
    fork
      begin
        @(negedge clk);
        stall_until = cyc + 34 + 20;
      end
      run_and_check("stall", 1, 5, 15'h500, 15'h600);
    join
    stall_until = 0;

    run_and_check("zero_tiles", 0, 9, 15'h010, 15'h020);
    run_and_check("zero_act", 2, 0, 15'h080, 15'h0A0);

    // abort on the 5th activation beat
    begin
      int beats, d0;
      d0 = done_cnt; beats = 0;
      start_run(2, 12, 15'h111, 15'h222);
      for (int i = 0; i < 2000 && beats < 5; i++) begin
        @(negedge clk);
        if (act_rd_en) beats++;
      end
      chk("abort_reached_beat5", beats, 5);
      cfg_abort = 1'b1;
      @(negedge clk);
      cfg_abort = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_act_rd_en", act_rd_en, 0);
      chk("abort_pe_valid", act_pe_valid, 0);
      chk("abort_w_rd_en", w_rd_en, 0);
      chk("abort_done", done, 0);
      chk("abort_pingpang", pingpang, pp_model);
      flush_all();
      repeat (5) @(negedge clk);
      chk("abort_no_done", done_cnt - d0, 0);
    end
    run_and_check("post_abort", 1, 6, 15'h123, 15'h456);

    // address wrap
    run_and_check("wrap", 2, 8, 15'h7FF0, 15'h7FFA);

    // reset in the middle of DRAIN
    begin
      int sc0;
      sc0 = sc_cnt;
      start_run(1, 4, 15'h700, 15'h710);
      for (int i = 0; i < 2000 && sc_cnt == sc0; i++) @(negedge clk);
      repeat (20) @(negedge clk);
      chk("pre_reset_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("reset_mid_drain", {w_rd_en, w_rd_addr, act_rd_en, act_rd_addr, act_pe_valid,
                              start_calc, pingpang, busy, done, tile_idx}, 0);
      flush_all();
      pp_model = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
    end

    // randomized runs with irregular bank latency
    rand_gaps = 1;
    for (int r = 0; r < 4; r++)
      run_and_check("rand", $urandom_range(1, 3), $urandom_range(0, 20),
                    ADDR_W'($urandom), ADDR_W'($urandom));
    rand_gaps = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
